// File: rtl/approx_pkg.sv
// Shared types and elaboration helpers for the approximate accumulation stage.
package approx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of the OR-approximated lower part of the adder.
  function automatic int lp_bits(input int dw, input int pct);
    return dw / pct;
  endfunction

endpackage

// File: rtl/approx_lp_add.sv
// Combinational DW-bit adder: lower-part-OR approximation or exact add, returning {co, sum}.
module approx_lp_add #(
  parameter int DW        = 19,
  parameter int LP        = 4,
  parameter bit APPROX_EN = 1'b1
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] sum,
  output logic          co
);

  generate
    if (APPROX_EN) begin : g_approx
      logic              cin;
      logic [DW-LP:0]    upper;

      // The top bits of the OR part feed a speculative carry into the exact upper adder.
      assign cin   = a[LP-1] & b[LP-1];
      assign upper = {1'b0, a[DW-1:LP]} + {1'b0, b[DW-1:LP]} + {{(DW-LP){1'b0}}, cin};
      assign sum   = {upper[DW-LP-1:0], a[LP-1:0] | b[LP-1:0]};
      assign co    = upper[DW-LP];
    end else begin : g_exact
      logic [DW:0] full;

      assign full = {1'b0, a} + {1'b0, b};
      assign sum  = full[DW-1:0];
      assign co   = full[DW];
    end
  endgenerate

endmodule

// File: rtl/approx_accum_stage.sv
// Accumulates cfg_len unsigned products with an (optionally approximate) adder and
// returns the sum over a valid/ready handshake.
module approx_accum_stage
  import approx_pkg::*;
#(
  parameter int DW_a       = 16,
  parameter int DW_b       = 19,
  parameter int DW_c       = max_w(DW_a, DW_b),
  parameter int percentage = 4,
  parameter int CW         = 8,
  parameter bit APPROX_EN  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CW-1:0]   cfg_len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW_a-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW_c-1:0] out_data,
  output logic            out_ovf,
  output logic            busy
);

  localparam int LP = lp_bits(DW_c, percentage);

  state_t          state;
  logic [DW_c-1:0] acc;
  logic [DW_c-1:0] in_ext;
  logic [DW_c-1:0] sum;
  logic            co;
  logic [CW-1:0]   len;
  logic [CW-1:0]   cnt;
  logic            ovf;

  assign in_ext = DW_c'(in_data);

  approx_lp_add #(
    .DW        (DW_c),
    .LP        (LP),
    .APPROX_EN (APPROX_EN)
  ) u_add (
    .a   (acc),
    .b   (in_ext),
    .sum (sum),
    .co  (co)
  );

  // in_ready/out_valid/busy are registered alongside the state so they always match it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      len       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && cfg_len != '0) begin
            len      <= cfg_len;
            acc      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= ACC;
          end
        end
        ACC: begin
          if (in_valid) begin
            acc <= sum;
            ovf <= ovf | co;
            cnt <= cnt + CW'(1);
            // Result is taken straight from the adder so it appears one cycle after the last accept.
            if (cnt == len - CW'(1)) begin
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= sum;
              out_ovf   <= ovf | co;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_approx_accum_stage.sv
// Directed bench for approx_accum_stage: approximate and exact instances run in lockstep.
module tb_approx_accum_stage;

  localparam int DW_A = 16;
  localparam int DW_C = 19;
  localparam int CW   = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [CW-1:0]   cfg_len;
  logic            in_valid;
  logic [DW_A-1:0] in_data;
  logic            out_ready;

  logic            in_ready, out_valid, out_ovf, busy;
  logic [DW_C-1:0] out_data;
  logic            x_in_ready, x_out_valid, x_out_ovf, x_busy;
  logic [DW_C-1:0] x_out_data;

  typedef struct {
    logic [DW_C-1:0] d;
    logic            o;
    logic [DW_C-1:0] x;
  } exp_t;

  exp_t            exp_q[$];
  int              n_cmp = 0;
  int              n_err = 0;
  logic [DW_A-1:0] terms[16];

  approx_accum_stage #(.APPROX_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  approx_accum_stage #(.APPROX_EN(1'b0)) dut_exact (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (x_in_ready),
    .in_data   (in_data),
    .out_valid (x_out_valid),
    .out_ready (out_ready),
    .out_data  (x_out_data),
    .out_ovf   (x_out_ovf),
    .busy      (x_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference approximate add with LP=4, written with shifts and masks on plain integers.
  function automatic logic [DW_C:0] model_add(input logic [DW_C-1:0] a, input logic [DW_C-1:0] b);
    int unsigned ua, ub, low, cin, up;
    ua  = a;
    ub  = b;
    low = (ua | ub) & 32'hF;
    cin = (ua >> 3) & (ub >> 3) & 32'h1;
    up  = (ua >> 4) + (ub >> 4) + cin;
    return {up[15], up[14:0], low[3:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic run_job(input string tag, input int n, input bit gaps, input int hold,
                         input logic [DW_C-1:0] e_d, input logic e_o, input logic [DW_C-1:0] e_x);
    int   acc_cnt = 0;
    int   budget  = 0;
    logic rdy;
    exp_t e;
    e.d = e_d;
    e.o = e_o;
    e.x = e_x;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start   = 1'b1;
    cfg_len = CW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    while (acc_cnt < n && budget < 200) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = terms[acc_cnt];
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (in_valid && rdy) acc_cnt++;
      budget++;
      #1 in_valid = 1'b0;
    end
    check({tag, "_accepted"}, acc_cnt, n);
    @(negedge clk);
    check({tag, "_latency_valid"}, out_valid, 1);
    e = exp_q.pop_front();
    check({tag, "_data"}, out_data, e.d);
    check({tag, "_ovf"}, out_ovf, e.o);
    check({tag, "_exact_data"}, x_out_data, e.x);
    check({tag, "_done_in_ready"}, in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_data"}, out_data, e.d);
      check({tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_busy_drop"}, busy, 0);
    check({tag, "_data_retained"}, out_data, e.d);
  endtask

  task automatic applyStimulus();
    logic [DW_C:0]   r;
    logic [DW_C-1:0] m_acc, m_x;
    logic            m_o;

    rst = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_ovf", out_ovf, 0);

    terms[0] = 16'h0003; terms[1] = 16'h0005;
    run_job("j1_3_5", 2, 1'b0, 0, 19'h00007, 1'b0, 19'h00008);

    terms[0] = 16'h0008; terms[1] = 16'h0008;
    run_job("j2_8_8", 2, 1'b0, 0, 19'h00018, 1'b0, 19'h00010);

    for (int i = 0; i < 3; i++) terms[i] = 16'hFFFF;
    run_job("j3_ffff_x3", 3, 1'b0, 0, 19'h2FFFF, 1'b0, 19'h2FFFD);

    for (int i = 0; i < 8; i++) terms[i] = 16'hFFFF;
    terms[8] = 16'h0010;
    run_job("j4_overflow", 9, 1'b0, 0, 19'h0000F, 1'b1, 19'h00008);

    terms[0] = 16'h0003; terms[1] = 16'h0005;
    run_job("j5_hold", 2, 1'b0, 5, 19'h00007, 1'b0, 19'h00008);

    m_acc = '0; m_o = 1'b0; m_x = '0;
    for (int i = 0; i < 6; i++) begin
      terms[i] = DW_A'($urandom);
      r     = model_add(m_acc, DW_C'(terms[i]));
      m_acc = r[DW_C-1:0];
      m_o   = m_o | r[DW_C];
      m_x   = m_x + DW_C'(terms[i]);
    end
    run_job("j6_gaps", 6, 1'b1, 1, m_acc, m_o, m_x);

    // Abort an accumulation after two of four terms.
    for (int i = 0; i < 4; i++) terms[i] = 16'h0101;
    @(posedge clk); #1;
    start = 1'b1; cfg_len = 8'd4;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = terms[0];
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_out_ovf", out_ovf, 0);

    in_valid = 1'b1; in_data = 16'h0007;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    terms[0] = 16'h0001;
    run_job("j7_len1", 1, 1'b0, 0, 19'h00001, 1'b0, 19'h00001);

    @(posedge clk); #1;
    start = 1'b1; cfg_len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("len0_busy", busy, 0);
    check("len0_in_ready", in_ready, 0);
  endtask

  task automatic checkOutput();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  initial begin
    applyStimulus();
    checkOutput();
    $finish;
  end

endmodule
